// File: rtl/qa_drv_tx_arbiter_pkg.sv
// Shared qa types for the CCI TX arbiter.
// Header width, backpressure and grant bundles.
package qa_drv_tx_arbiter_pkg;

  localparam int QA_HDR_WIDTH = 61;

  typedef logic [QA_HDR_WIDTH-1:0] qa_hdr_t;

  typedef struct packed {
    logic c0;
    logic c1;
  } qa_af_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } qa_gnt_t;

  function automatic int qa_wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/qa_drv_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant.
// Pointer holds the index where the next search starts.
module qa_drv_rr_arbiter
  import qa_drv_tx_arbiter_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          enable,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_q
);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[(int'(ptr_q) + k) % N]) begin
          grant[(int'(ptr_q) + k) % N] = 1'b1;
          win   = PW'((int'(ptr_q) + k) % N);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      clr:     ptr_d = '0;
      found:   ptr_d = PW'(qa_wrap_inc(int'(win), N));
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/qa_drv_tx_arbiter.sv
// Shares CCI TX0 (read) and TX1 (write) among N_REQ requesters.
// Reads are credit-limited by the outstanding-read counter.
module qa_drv_tx_arbiter
  import qa_drv_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int HDR_WIDTH  = QA_HDR_WIDTH,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_RD_OUT = 32,
  localparam int OUT_W     = $clog2(MAX_RD_OUT + 1)
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic                        afu_en,
  input  logic [N_REQ-1:0]            rd_req,
  input  logic [N_REQ*HDR_WIDTH-1:0]  rd_hdr,
  output logic [N_REQ-1:0]            rd_grant,
  input  logic [N_REQ-1:0]            wr_req,
  input  logic [N_REQ*HDR_WIDTH-1:0]  wr_hdr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]            wr_grant,
  input  logic                        c0_almostfull,
  input  logic                        c1_almostfull,
  input  logic                        rx0_rdvalid,
  output logic                        tx0_rdvalid,
  output logic [HDR_WIDTH-1:0]        tx0_hdr,
  output logic                        tx1_wrvalid,
  output logic [HDR_WIDTH-1:0]        tx1_hdr,
  output logic [DATA_WIDTH-1:0]       tx1_data,
  output logic [OUT_W-1:0]            rd_outstanding,
  output logic                        err_underflow
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  qa_af_t  af;
  qa_gnt_t any;

  logic rd_en;
  logic wr_en;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic unused_ptrs;

  logic [HDR_WIDTH-1:0]  rd_sel;
  logic [HDR_WIDTH-1:0]  wr_sel;
  logic [DATA_WIDTH-1:0] wd_sel;

  logic                  tx0_v_q;
  logic [HDR_WIDTH-1:0]  tx0_h_q;
  logic                  tx1_v_q;
  logic [HDR_WIDTH-1:0]  tx1_h_q;
  logic [DATA_WIDTH-1:0] tx1_d_q;
  logic [OUT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  assign af.c0 = c0_almostfull;
  assign af.c1 = c1_almostfull;

  // Gating with resetb keeps grants low while reset is held.
  assign rd_en = resetb & afu_en & ~af.c0
               & (cnt_q < OUT_W'(MAX_RD_OUT));
  assign wr_en = resetb & afu_en & ~af.c1;

  qa_drv_rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk    (clk),
    .rst_n  (resetb),
    .clr    (~afu_en),
    .enable (rd_en),
    .req    (rd_req),
    .grant  (rd_grant),
    .ptr_q  (rd_ptr)
  );

  qa_drv_rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk    (clk),
    .rst_n  (resetb),
    .clr    (~afu_en),
    .enable (wr_en),
    .req    (wr_req),
    .grant  (wr_grant),
    .ptr_q  (wr_ptr)
  );

  assign unused_ptrs = ^{rd_ptr, wr_ptr};

  assign any.rd = |rd_grant;
  assign any.wr = |wr_grant;

  always_comb begin
    rd_sel = '0;
    wr_sel = '0;
    wd_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rd_grant[i]) rd_sel = rd_hdr[i*HDR_WIDTH +: HDR_WIDTH];
      if (wr_grant[i]) begin
        wr_sel = wr_hdr[i*HDR_WIDTH +: HDR_WIDTH];
        wd_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant and response together cancel, even at zero.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({any.rd, rx0_rdvalid})
      2'b10: cnt_d = cnt_q + OUT_W'(1);
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - OUT_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx0_v_q <= 1'b0;
      tx0_h_q <= '0;
      tx1_v_q <= 1'b0;
      tx1_h_q <= '0;
      tx1_d_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      tx0_v_q <= any.rd;
      tx1_v_q <= any.wr;
      if (any.rd) tx0_h_q <= rd_sel;
      if (any.wr) begin
        tx1_h_q <= wr_sel;
        tx1_d_q <= wd_sel;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign tx0_rdvalid    = tx0_v_q;
  assign tx0_hdr        = tx0_h_q;
  assign tx1_wrvalid    = tx1_v_q;
  assign tx1_hdr        = tx1_h_q;
  assign tx1_data       = tx1_d_q;
  assign rd_outstanding = cnt_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_qa_drv_tx_arbiter.sv
// Bench for qa_drv_tx_arbiter: directed scenarios plus random
// traffic, checked against a rule-level reference model.
module tb_qa_drv_tx_arbiter;

  localparam int N    = 3;
  localparam int HW   = 61;
  localparam int DW   = 512;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic resetb;
  logic afu_en;
  logic [N-1:0] rd_req, wr_req;
  logic [N*HW-1:0] rd_hdr, wr_hdr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0] rd_grant, wr_grant;
  logic c0_almostfull, c1_almostfull, rx0_rdvalid;
  logic tx0_rdvalid, tx1_wrvalid;
  logic [HW-1:0] tx0_hdr, tx1_hdr;
  logic [DW-1:0] tx1_data;
  logic [OW-1:0] rd_outstanding;
  logic err_underflow;

  int vectors = 0;
  int miscompares = 0;

  int m_rptr, m_wptr, m_cnt;
  bit m_err;
  bit exp_rv, exp_wv;
  logic [HW-1:0] exp_rh, exp_wh;
  logic [DW-1:0] exp_wd;

  always #5 clk = ~clk;

  qa_drv_tx_arbiter #(
    .N_REQ(N), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .MAX_RD_OUT(MAXO)
  ) dut (
    .clk(clk), .resetb(resetb), .afu_en(afu_en),
    .rd_req(rd_req), .rd_hdr(rd_hdr), .rd_grant(rd_grant),
    .wr_req(wr_req), .wr_hdr(wr_hdr), .wr_data(wr_data),
    .wr_grant(wr_grant),
    .c0_almostfull(c0_almostfull), .c1_almostfull(c1_almostfull),
    .rx0_rdvalid(rx0_rdvalid),
    .tx0_rdvalid(tx0_rdvalid), .tx0_hdr(tx0_hdr),
    .tx1_wrvalid(tx1_wrvalid), .tx1_hdr(tx1_hdr),
    .tx1_data(tx1_data),
    .rd_outstanding(rd_outstanding),
    .err_underflow(err_underflow)
  );

  task automatic chk(string tag, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First asserted request at or after start, wrapping.
  function automatic int pick(int start, logic [N-1:0] req, bit en);
    if (!en) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rptr = 0; m_wptr = 0; m_cnt = 0; m_err = 0;
    exp_rv = 0; exp_wv = 0;
    exp_rh = '0; exp_wh = '0; exp_wd = '0;
  endtask

  task automatic payload();
    logic [2047:0] t;
    for (int j = 0; j < 64; j++) t[j*32 +: 32] = $urandom;
    rd_hdr = t[N*HW-1:0];
    for (int j = 0; j < 64; j++) t[j*32 +: 32] = $urandom;
    wr_hdr = t[N*HW-1:0];
    for (int j = 0; j < 64; j++) t[j*32 +: 32] = $urandom;
    wr_data = t[N*DW-1:0];
  endtask

  task automatic step();
    int ri, wi;
    logic [N-1:0] er, ew;
    #1;
    ri = pick(m_rptr, rd_req, afu_en && !c0_almostfull && m_cnt < MAXO);
    wi = pick(m_wptr, wr_req, afu_en && !c1_almostfull);
    er = '0; ew = '0;
    if (ri >= 0) er[ri] = 1'b1;
    if (wi >= 0) ew[wi] = 1'b1;
    chk("rd_grant", DW'(rd_grant), DW'(er));
    chk("wr_grant", DW'(wr_grant), DW'(ew));
    exp_rv = (ri >= 0);
    exp_wv = (wi >= 0);
    if (ri >= 0) begin
      exp_rh = rd_hdr[ri*HW +: HW];
      m_rptr = (ri + 1) % N;
    end
    if (wi >= 0) begin
      exp_wh = wr_hdr[wi*HW +: HW];
      exp_wd = wr_data[wi*DW +: DW];
      m_wptr = (wi + 1) % N;
    end
    if (!afu_en) begin
      m_rptr = 0; m_wptr = 0;
    end
    if (ri >= 0 && !rx0_rdvalid) m_cnt++;
    else if (ri < 0 && rx0_rdvalid) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    @(posedge clk); #1;
    chk("tx0_rdvalid", DW'(tx0_rdvalid), DW'(exp_rv));
    chk("tx1_wrvalid", DW'(tx1_wrvalid), DW'(exp_wv));
    if (exp_rv) chk("tx0_hdr", DW'(tx0_hdr), DW'(exp_rh));
    if (exp_wv) begin
      chk("tx1_hdr", DW'(tx1_hdr), DW'(exp_wh));
      chk("tx1_data", tx1_data, exp_wd);
    end
    chk("rd_outstanding", DW'(rd_outstanding), DW'(m_cnt));
    chk("err_underflow", DW'(err_underflow), DW'(m_err));
    @(negedge clk);
  endtask

  task automatic drive(bit en, logic [N-1:0] rr, logic [N-1:0] ww,
                       bit a0, bit a1, bit rx);
    afu_en = en; rd_req = rr; wr_req = ww;
    c0_almostfull = a0; c1_almostfull = a1; rx0_rdvalid = rx;
    payload();
    step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".rd_grant"}, DW'(rd_grant), '0);
    chk({tag, ".wr_grant"}, DW'(wr_grant), '0);
    chk({tag, ".tx0_rdvalid"}, DW'(tx0_rdvalid), '0);
    chk({tag, ".tx1_wrvalid"}, DW'(tx1_wrvalid), '0);
    chk({tag, ".tx0_hdr"}, DW'(tx0_hdr), '0);
    chk({tag, ".tx1_hdr"}, DW'(tx1_hdr), '0);
    chk({tag, ".tx1_data"}, tx1_data, '0);
    chk({tag, ".rd_outstanding"}, DW'(rd_outstanding), '0);
    chk({tag, ".err_underflow"}, DW'(err_underflow), '0);
  endtask

  initial begin
    resetb = 1'b0;
    afu_en = 1'b1; rd_req = '1; wr_req = '1;
    c0_almostfull = 0; c1_almostfull = 0; rx0_rdvalid = 0;
    payload();
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetb = 1'b1;

    // Round robin over all three readers, with responses to stay
    // under the credit limit.
    for (int c = 0; c < 6; c++) drive(1, 3'b111, 3'b000, 0, 0, c >= 2);
    while (m_cnt > 0) drive(1, 3'b000, 3'b000, 0, 0, 1);

    // Backpressure on TX0.
    for (int c = 0; c < 3; c++) drive(1, 3'b001, 3'b000, 1, 0, 0);
    drive(1, 3'b001, 3'b000, 0, 0, 0);
    drive(1, 3'b000, 3'b000, 0, 0, 1);

    // Credit limit, then one response frees one slot.
    for (int c = 0; c < 6; c++) drive(1, 3'b111, 3'b000, 0, 0, 0);
    drive(1, 3'b111, 3'b000, 0, 0, 1);
    drive(1, 3'b111, 3'b000, 0, 0, 0);
    drive(1, 3'b111, 3'b000, 0, 0, 0);

    // Grant and response together at count 2, then underflow.
    drive(1, 3'b000, 3'b000, 0, 0, 1);
    drive(1, 3'b000, 3'b000, 0, 0, 1);
    drive(1, 3'b010, 3'b000, 0, 0, 1);
    drive(1, 3'b000, 3'b000, 0, 0, 1);
    drive(1, 3'b000, 3'b000, 0, 0, 1);
    drive(1, 3'b000, 3'b000, 0, 0, 1);

    // Read and write to the same requester together.
    drive(1, 3'b001, 3'b001, 0, 0, 0);
    drive(1, 3'b000, 3'b110, 0, 0, 1);

    // Disable returns pointers to zero.
    drive(1, 3'b110, 3'b110, 0, 0, 0);
    drive(0, 3'b111, 3'b111, 0, 0, 1);
    drive(1, 3'b111, 3'b111, 0, 0, 0);

    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 15) != 0, N'($urandom), N'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset pulse mid-stream.
    afu_en = 1; rd_req = 3'b111; wr_req = 3'b111;
    c0_almostfull = 0; c1_almostfull = 0; rx0_rdvalid = 0;
    drive(1, 3'b110, 3'b110, 0, 0, 0);
    #2 resetb = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    #4 resetb = 1'b1;
    @(negedge clk);
    chk("post_reset.tx0_rdvalid", DW'(tx0_rdvalid), '0);
    chk("post_reset.tx1_wrvalid", DW'(tx1_wrvalid), '0);
    drive(1, 3'b111, 3'b111, 0, 0, 0);
    drive(1, 3'b111, 3'b111, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qa_drv_tx_arbiter.md
QA_DRV_TX_ARBITER -- requirements
Module: qa_drv_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, the number of requesters sharing the CCI TX channels.
REQ-002 SHALL have parameter HDR_WIDTH, default 61, the width of the TX request header.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, the width of one cache line.
REQ-004 SHALL have parameter MAX_RD_OUT, default 32, the maximum number of outstanding reads; OUT_W = clog2(MAX_RD_OUT+1).
REQ-005 SHALL have one clock and an asynchronous active-low reset; the ports SHALL be as follows.
- clk  in  1  clock.
- resetb  in  1  async active-low reset.
- afu_en  in  1  AFU enable from CSR.
- rd_req  in  N_REQ  per-requester read request.
- rd_hdr  in  N_REQ*HDR_WIDTH  read headers; slice i belongs to requester i.
- rd_grant  out  N_REQ  one-hot read grant.
- wr_req  in  N_REQ  per-requester write request.
- wr_hdr  in  N_REQ*HDR_WIDTH  write headers.
- wr_data  in  N_REQ*DATA_WIDTH  write data.
- wr_grant  out  N_REQ  one-hot write grant.
- c0_almostfull  in  1  TX0 (read) backpressure.
- c1_almostfull  in  1  TX1 (write) backpressure.
- rx0_rdvalid  in  1  read response returned.
- tx0_rdvalid  out  1  TX0 read issue.
- tx0_hdr  out  HDR_WIDTH  TX0 header.
- tx1_wrvalid  out  1  TX1 write issue.
- tx1_hdr  out  HDR_WIDTH  TX1 header.
- tx1_data  out  DATA_WIDTH  TX1 data.
- rd_outstanding  out  OUT_W  count of reads in flight.
- err_underflow  out  1  sticky flag: a response arrived with zero reads outstanding.

Function
REQ-006 rd_grant SHALL be combinational in the request cycle; a requester treats grant&req as accepted and advances its state that same cycle.
REQ-007 rd_grant SHALL be all-zero unless afu_en=1, c0_almostfull=0 and rd_outstanding<MAX_RD_OUT; otherwise exactly one bit SHALL be set, and only for an asserted rd_req.
REQ-008 Read arbitration SHALL be round-robin: search begins at index (last read winner+1) mod N_REQ; the pointer SHALL update only on a grant.
REQ-009 wr_grant SHALL follow REQ-007/REQ-008 independently, using c1_almostfull and no credit limit; the read and write pointers are independent.
REQ-010 tx0_rdvalid/tx0_hdr SHALL be registered: asserted exactly one cycle after a read grant, carrying that winner's rd_hdr slice as sampled in the grant cycle.
REQ-011 tx1_wrvalid/tx1_hdr/tx1_data SHALL be registered in the same way from the write winner; tx*_valid SHALL be 0 in any cycle following a no-grant cycle.
REQ-012 rd_outstanding SHALL be +1 on a read grant, -1 on rx0_rdvalid, and unchanged when both occur in the same cycle.
REQ-013 rx0_rdvalid with rd_outstanding=0 and no grant SHALL leave the count at 0 and set err_underflow (cleared only by reset).
REQ-014 afu_en=0 SHALL suppress all grants and return both RR pointers to 0 on the next edge; rd_outstanding SHALL keep tracking responses.
REQ-015 A read and a write grant in the same cycle SHALL both be permitted, including to the same requester.

Reset
REQ-016 Assertion of resetb=0 SHALL asynchronously force the following to zero: grants-derived registers, tx0_rdvalid, tx1_wrvalid, tx0_hdr, tx1_hdr, tx1_data, rd_outstanding, err_underflow, and both RR pointers.
REQ-017 Reset mid-operation SHALL discard in-flight issue registers, and no tx valid SHALL be asserted in the first cycle after deassertion.

Structure
REQ-018 The header type, HDR_WIDTH, and the almost-full/grant struct types SHALL live in the shared qa package header, not in this module.
REQ-019 A single sub-module, qa_drv_rr_arbiter (parameter N; inputs req, enable; outputs one-hot grant, registered pointer), SHALL be instantiated once per channel.

Verification
REQ-020 Directed scenario: rd_req=3'b111 held for 6 cycles -> rd_grant sequence 001,010,100,001,010,100; tx0_rdvalid high on cycles 2-7 with the matching headers.
REQ-021 Directed scenario: c0_almostfull=1 for 3 cycles with rd_req=3'b001 -> no grant and no tx0_rdvalid during those cycles; grant resumes the cycle after c0_almostfull falls.
REQ-022 Directed scenario: MAX_RD_OUT=4, continuous reads, no responses -> exactly 4 grants, rd_outstanding=4; one rx0_rdvalid -> one further grant.
REQ-023 Directed scenario: simultaneous grant and rx0_rdvalid at count 2 -> count stays 2; rx0_rdvalid at count 0 -> count stays 0 and err_underflow=1.
REQ-024 Directed scenario: rd_req=3'b001 and wr_req=3'b001 together -> rd_grant=001 and wr_grant=001 in the same cycle; tx0 and tx1 both valid on the next cycle.
REQ-025 Directed scenario: resetb pulsed low mid-stream, asynchronous to clk -> all outputs 0 immediately, pointers at 0, and the first grant after reset goes to requester 0.
